ro_measure_sequencer: RTL and testbench

//  Sequences frequency measurements over the 64-entry ring-oscillator bank (two 32-RO sets, one enable each).

---
 rtl/ro_measure_sequencer.sv | 142 ++++++++++++++
 tb/tb_ro_measure_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_measure_sequencer.sv
// Ring-oscillator frequency sweep: enables the RO set for each index, settles,
// counts synchronized rising edges over a gate window, and hands back results.
module ro_measure_sequencer #(
    parameter int NUM_RO     = 64,
    parameter int IDX_W      = 6,
    parameter int GATE_W     = 16,
    parameter int COUNT_W    = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [IDX_W-1:0]   first_idx,
    input  logic [IDX_W-1:0]   last_idx,
    input  logic [GATE_W-1:0]  gate_len,
    input  logic               ro_in,
    output logic               ro_activate_1,
    output logic               ro_activate_2,
    output logic [IDX_W-1:0]   ro_sel,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COUNT_W-1:0] res_count,
    output logic [IDX_W-1:0]   res_idx,
    output logic               res_sat,
    output logic               done
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (GATE_W > SET_W) ? GATE_W : SET_W;
    localparam logic [TMR_W-1:0] SETTLE_M1 = TMR_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, GATE, REPORT, DONE} state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   cur_idx, last_q;
    logic [GATE_W-1:0]  gate_q;
    logic [TMR_W-1:0]   tmr, gate_m1;
    logic [COUNT_W-1:0] count;
    logic               sat;
    logic [2:0]         ro_pipe;
    logic               rise;
    logic               accept;
    logic               last_hit;
    logic [IDX_W-1:0]   next_idx;

    assign accept   = (state == IDLE) && start && !abort;
    assign last_hit = (cur_idx == last_q);
    assign next_idx = (cur_idx == IDX_W'(NUM_RO - 1)) ? '0 : cur_idx + 1'b1;
    // A zero gate length still opens the window for one cycle.
    assign gate_m1  = (gate_q == '0) ? '0 : TMR_W'(gate_q) - TMR_W'(1);
    assign rise     = ro_pipe[1] & ~ro_pipe[2];

    // ro_pipe[1:0] is the 2-flop synchronizer, ro_pipe[2] the edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            ro_pipe <= '0;
        end else begin
            ro_pipe[1:0] <= {ro_pipe[0], ro_in};
            ro_pipe[2]   <= (state == SETTLE) ? 1'b0 : ro_pipe[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = SETTLE;
            SETTLE:  if (tmr == '0) state_n = GATE;
            GATE:    if (tmr == '0) state_n = REPORT;
            REPORT:  if (res_ready) state_n = last_hit ? DONE : SETTLE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_idx <= '0;
            last_q  <= '0;
            gate_q  <= '0;
            tmr     <= '0;
            count   <= '0;
            sat     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_idx <= first_idx;
                        last_q  <= last_idx;
                        gate_q  <= gate_len;
                        tmr     <= SETTLE_M1;
                    end
                end
                SETTLE: begin
                    count <= '0;
                    sat   <= 1'b0;
                    tmr   <= (tmr == '0) ? gate_m1 : tmr - 1'b1;
                end
                GATE: begin
                    if (tmr != '0) tmr <= tmr - 1'b1;
                    if (rise) begin
                        if (count == '1) sat <= 1'b1;
                        else             count <= count + 1'b1;
                    end
                end
                REPORT: begin
                    if (res_ready && !last_hit) begin
                        cur_idx <= next_idx;
                        tmr     <= SETTLE_M1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Activation only while settling/gating; the top index bit picks the set.
    always_comb begin
        ro_activate_1 = 1'b0;
        ro_activate_2 = 1'b0;
        if (state == SETTLE || state == GATE) begin
            ro_activate_1 = ~cur_idx[IDX_W-1];
            ro_activate_2 =  cur_idx[IDX_W-1];
        end
    end

    assign busy      = (state != IDLE);
    assign res_valid = (state == REPORT);
    assign done      = (state == DONE);
    assign ro_sel    = cur_idx;
    assign res_idx   = cur_idx;
    assign res_count = count;
    assign res_sat   = sat;

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Scoreboard bench for ro_measure_sequencer: directed sweeps push expected
// results; monitors pop and compare on each result handshake.
module tb_ro_measure_sequencer;

    localparam int IDX_W  = 6;
    localparam int GATE_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, start_b = 1'b0, abort = 1'b0, ro_in = 1'b0, res_ready = 1'b1;
    logic [IDX_W-1:0]  first_idx = '0, last_idx = '0;
    logic [GATE_W-1:0] gate_len = '0;

    logic act1, act2, busy, res_valid, res_sat, done;
    logic [IDX_W-1:0] ro_sel, res_idx;
    logic [15:0] res_count;
    logic act1_b, act2_b, busy_b, res_valid_b, res_sat_b, done_b;
    logic [IDX_W-1:0] ro_sel_b, res_idx_b;
    logic [3:0] res_count_b;

    ro_measure_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .first_idx(first_idx), .last_idx(last_idx), .gate_len(gate_len), .ro_in(ro_in),
        .ro_activate_1(act1), .ro_activate_2(act2), .ro_sel(ro_sel), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
        .res_idx(res_idx), .res_sat(res_sat), .done(done)
    );

    ro_measure_sequencer #(.COUNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .first_idx(first_idx), .last_idx(last_idx), .gate_len(gate_len), .ro_in(ro_in),
        .ro_activate_1(act1_b), .ro_activate_2(act2_b), .ro_sel(ro_sel_b), .busy(busy_b),
        .res_valid(res_valid_b), .res_ready(res_ready), .res_count(res_count_b),
        .res_idx(res_idx_b), .res_sat(res_sat_b), .done(done_b)
    );

    always #5 clk = ~clk;

    // ro_mode 0: low; 1: one rising edge every 4 clk; 2: toggles every clk.
    int ro_mode = 0;
    initial begin
        #2;
        forever begin
            case (ro_mode)
                1: begin ro_in = 1'b1; #20; ro_in = 1'b0; #20; end
                2: begin ro_in = 1'b1; #10; ro_in = 1'b0; #10; end
                default: begin ro_in = 1'b0; #5; end
            endcase
        end
    end

    typedef struct {int idx; int lo; int hi; int sat; int act;} exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int errors = 0, checks = 0;
    int done_a = 0, done_bc = 0, both_on = 0;
    logic [1:0] last_act_a = '0, last_act_b = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Monitor for the default-width instance.
    always @(negedge clk) begin
        if (act1 && act2) both_on++;
        if (act1 || act2) last_act_a = {act2, act1};
        if (!rst && done) done_a++;
        if (!rst && res_valid && res_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result_idx", int'(res_idx), -1);
            end else begin
                ea = qa.pop_front();
                chk("a_idx", int'(res_idx), ea.idx);
                chk_rng("a_count", int'(res_count), ea.lo, ea.hi);
                chk("a_sat", int'(res_sat), ea.sat);
                chk("a_act_seen", int'(last_act_a), ea.act);
                chk("a_act_in_report", int'({act2, act1}), 0);
            end
        end
    end

    // Monitor for the 4-bit counter instance.
    always @(negedge clk) begin
        if (act1_b && act2_b) both_on++;
        if (act1_b || act2_b) last_act_b = {act2_b, act1_b};
        if (!rst && done_b) done_bc++;
        if (!rst && res_valid_b && res_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result_idx", int'(res_idx_b), -1);
            end else begin
                eb = qb.pop_front();
                chk("b_idx", int'(res_idx_b), eb.idx);
                chk_rng("b_count", int'(res_count_b), eb.lo, eb.hi);
                chk("b_sat", int'(res_sat_b), eb.sat);
                chk("b_act_seen", int'(last_act_b), eb.act);
            end
        end
    end

    task automatic push_a(input int idx, input int lo, input int hi, input int sat, input int act);
        exp_t e;
        e = '{idx, lo, hi, sat, act};
        qa.push_back(e);
    endtask

    task automatic launch(input int f, input int l, input int g);
        @(posedge clk); #1;
        first_idx = f[IDX_W-1:0];
        last_idx  = l[IDX_W-1:0];
        gate_len  = g[GATE_W-1:0];
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        exp_t e;
        // Reset held with start asserted.
        rst = 1'b1; start = 1'b1; first_idx = 6'd5; last_idx = 6'd5; gate_len = 16'd100;
        ro_mode = 1;
        push_a(5, 24, 26, 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_act", int'({act2, act1}), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_res_count", int'(res_count), 0);
        chk("rst_res_idx", int'(res_idx), 0);
        chk("rst_ro_sel", int'(ro_sel), 0);
        chk("rst_res_sat", int'(res_sat), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t1_busy_first_cycle", int'(busy), 1);
        chk("t2_act1_on", int'(act1), 1);
        chk("t2_act2_off", int'(act2), 0);
        chk("t2_ro_sel", int'(ro_sel), 5);

        // Single RO: activation spans settle + gate.
        n = 0;
        @(negedge clk);
        while (act1 && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk("t2_act1_cycles", n, 108);
        chk("t2_valid_at_gate_end", int'(res_valid), 1);
        wait_idle("t2_idle_timeout", 50);
        chk("t2_done_count", done_a, 1);

        // start together with abort is ignored.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("abort_blocks_start", int'(busy), 0);

        // Wrapping sweep 62..1; a start mid-sweep must be ignored.
        ro_mode = 2;
        push_a(62, 5, 5, 0, 2);
        push_a(63, 5, 5, 0, 2);
        push_a(0, 5, 5, 0, 1);
        push_a(1, 5, 5, 0, 1);
        launch(62, 1, 10);
        @(posedge clk); #1;
        start = 1'b1; first_idx = 6'd30; last_idx = 6'd30;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("t3_idle_timeout", 400);
        chk("t3_done_count", done_a, 2);
        chk("t3_queue_empty", qa.size(), 0);

        // Saturation on the 4-bit counter instance.
        e = '{3, 15, 15, 1, 1};
        qb.push_back(e);
        @(posedge clk); #1;
        first_idx = 6'd3; last_idx = 6'd3; gate_len = 16'd40;
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        n = 0;
        while (busy_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_idle_timeout", int'(busy_b), 0);
        chk("t4_done_count", done_bc, 1);
        chk("t4_queue_empty", qb.size(), 0);

        // Backpressure in REPORT.
        res_ready = 1'b0;
        push_a(20, 5, 5, 0, 1);
        push_a(21, 5, 5, 0, 1);
        launch(20, 21, 10);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_valid_seen", int'(res_valid), 1);
        for (int k = 0; k < 5; k++) begin
            repeat (10) @(negedge clk);
            chk("t5_hold_valid", int'(res_valid), 1);
            chk("t5_hold_count", int'(res_count), 5);
            chk("t5_hold_idx", int'(res_idx), 20);
            chk("t5_hold_act", int'({act2, act1}), 0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_next_sel", int'(ro_sel), 21);
        chk("t5_next_act1", int'(act1), 1);
        chk("t5_valid_dropped", int'(res_valid), 0);
        wait_idle("t5_idle_timeout", 100);
        chk("t5_done_count", done_a, 3);

        // Abort mid-gate of a 3-RO sweep, then a fresh start.
        ro_mode = 1;
        launch(10, 12, 200);
        repeat (30) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t6_busy", int'(busy), 0);
        chk("t6_act", int'({act2, act1}), 0);
        chk("t6_res_valid", int'(res_valid), 0);
        repeat (300) @(negedge clk);
        chk("t6_no_done", done_a, 3);
        ro_mode = 2;
        push_a(40, 5, 5, 0, 2);
        launch(40, 40, 10);
        wait_idle("t6_idle_timeout", 100);
        chk("t6_done_after_restart", done_a, 4);
        chk("t6_queue_empty", qa.size(), 0);

        // Reset mid-gate returns everything to reset values.
        launch(33, 34, 50);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_act", int'({act2, act1}), 0);
        chk("rst_mid_count", int'(res_count), 0);
        chk("rst_mid_idx", int'(res_idx), 0);
        chk("rst_mid_sel", int'(ro_sel), 0);
        repeat (5) @(negedge clk);

        chk("act_both_on_cycles", both_on, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
